// File: rtl/spi_target_rx_if.sv
// SPI pin and fabric-side handshake bundle for spi_target_rx.
// The slave modport is the target engine; master is its environment.
interface spi_target_rx_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_pending;
    logic       overrun;
    logic       frame_err;
    logic       active;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, rx_ready, tx_data, tx_load,
        output spi_miso, rx_data, rx_valid, tx_pending, overrun, frame_err, active
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, rx_ready, tx_data, tx_load,
        input  spi_miso, rx_data, rx_valid, tx_pending, overrun, frame_err, active
    );
endinterface

// File: rtl/spi_target_rx.sv
// SPI mode-0 target: oversampled pins, RX byte FIFO with valid/ready, one-deep TX reply buffer.
// Everything runs in the clk domain; SPI inputs pass through SYNC_STAGES synchronizer flops.
module spi_target_rx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    spi_target_rx_if.slave bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // Input synchronizers plus one registered copy for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // Frame FSM.
    state_e state_q, state_d;
    logic   in_shift, shift_en, fall_en, abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cs_fall) state_d = StShift;
            StShift: if (cs_rise) state_d = StIdle;
        endcase
    end

    logic [2:0] bit_cnt_q, bit_cnt_d;

    // A CS rise in the same cycle as an SCLK rise suppresses the SCLK edge.
    always_comb begin
        in_shift = (state_q == StShift);
        shift_en = in_shift & sclk_rise & ~cs_rise;
        fall_en  = in_shift & sclk_fall;
        abort    = in_shift & cs_rise & (bit_cnt_q != 3'd0);
    end

    // Byte framing and TX shifter.
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_pending_q, tx_pending_d;
    logic       byte_done, reload;
    logic [7:0] push_byte;

    assign byte_done = shift_en & (bit_cnt_q == 3'd7);
    assign push_byte = {rx_shift_q[6:0], mosi_s};
    assign reload    = cs_fall | byte_done;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        if (cs_fall) begin
            bit_cnt_d  = 3'd0;
            rx_shift_d = 8'h00;
        end else if (shift_en) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            rx_shift_d = push_byte;
        end
    end

    // The first falling edge of a byte must not shift so the MSB holds for the first sample.
    always_comb begin
        tx_shift_d   = tx_shift_q;
        tx_buf_d     = tx_buf_q;
        tx_pending_d = tx_pending_q;
        if (reload) begin
            tx_shift_d   = tx_pending_q ? tx_buf_q : 8'hFF;
            tx_pending_d = 1'b0;
        end else if (fall_en && (bit_cnt_q != 3'd0)) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
        if (bus.tx_load) begin
            tx_buf_d     = bus.tx_data;
            tx_pending_d = 1'b1;
        end
    end

    // RX FIFO.
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pop, push_ok, overrun_d, overrun_q, frame_err_q;

    assign pop       = (count_q != '0) & bus.rx_ready;
    assign push_ok   = byte_done & ((count_q != CntFull) | pop);
    assign overrun_d = byte_done & ~push_ok;

    always_comb begin
        wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 8'h00;
            tx_shift_q   <= 8'hFF;
            tx_buf_q     <= 8'h00;
            tx_pending_q <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            tx_buf_q     <= tx_buf_d;
            tx_pending_q <= tx_pending_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= abort;
            if (push_ok) mem_q[wptr_q] <= push_byte;
        end
    end

    assign bus.spi_miso   = in_shift & tx_shift_q[7];
    assign bus.rx_data    = mem_q[rptr_q];
    assign bus.rx_valid   = (count_q != '0);
    assign bus.tx_pending = tx_pending_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.active     = in_shift;
endmodule

// File: tb/tb_spi_target_rx.sv
// Directed bench for spi_target_rx: an event-level model (FIFO queue, frame flag, reply flag)
// checked every cycle, plus literal expectations for received and replied bytes.
module tb_spi_target_rx;
    localparam int unsigned Depth = 4;
    localparam int unsigned Sync  = 2;
    localparam int unsigned Half  = 4;
    localparam int unsigned Lat   = Sync + 1;
    localparam int EvCsFall = 0;
    localparam int EvCsRise = 1;
    localparam int EvByte   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   ovr_seen = 0;
    int   ferr_seen = 0;

    spi_target_rx_if bus ();

    spi_target_rx #(.FIFO_DEPTH(Depth), .SYNC_STAGES(Sync)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned dly;
        int          kind;
        logic [7:0]  data;
        bit          partial;
    } ev_t;

    // Pin-level events take effect Lat clock edges after the pin changes.
    ev_t        ev_q[$];
    logic [7:0] m_fifo[$];
    bit         m_active = 1'b0, m_pending = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    bit         md_pop, md_full, md_push, md_reload;
    logic [7:0] md_data;
    ev_t        md_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            ev_q.delete();
            m_active  = 1'b0;
            m_pending = 1'b0;
            m_ovr     = 1'b0;
            m_ferr    = 1'b0;
        end else begin
            md_pop    = bus.rx_ready && (m_fifo.size() > 0);
            md_full   = (m_fifo.size() == Depth);
            md_push   = 1'b0;
            md_reload = 1'b0;
            md_data   = 8'h00;
            m_ovr     = 1'b0;
            m_ferr    = 1'b0;
            foreach (ev_q[i]) ev_q[i].dly--;
            while (ev_q.size() > 0 && ev_q[0].dly == 0) begin
                md_e = ev_q.pop_front();
                case (md_e.kind)
                    EvCsFall: begin m_active = 1'b1; md_reload = 1'b1; end
                    EvCsRise: begin
                        if (m_active && md_e.partial) m_ferr = 1'b1;
                        m_active = 1'b0;
                    end
                    default:  begin md_push = 1'b1; md_data = md_e.data; md_reload = 1'b1; end
                endcase
            end
            if (md_pop) void'(m_fifo.pop_front());
            if (md_push) begin
                if (!md_full || md_pop) m_fifo.push_back(md_data);
                else m_ovr = 1'b1;
            end
            if (bus.tx_load) m_pending = 1'b1;
            else if (md_reload) m_pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rx_valid", 32'(bus.rx_valid), 32'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) chk("rx_data", 32'(bus.rx_data), 32'(m_fifo[0]));
            chk("active", 32'(bus.active), 32'(m_active));
            chk("tx_pending", 32'(bus.tx_pending), 32'(m_pending));
            chk("overrun", 32'(bus.overrun), 32'(m_ovr));
            chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
            if (!m_active) chk("miso_idle", 32'(bus.spi_miso), 32'd0);
        end
        if (bus.overrun === 1'b1) ovr_seen++;
        if (bus.frame_err === 1'b1) ferr_seen++;
    end

    int         frame_bits = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] s;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sched(input int kind, input logic [7:0] d, input bit partial);
        ev_t e;
        e.dly = Lat; e.kind = kind; e.data = d; e.partial = partial;
        ev_q.push_back(e);
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        frame_bits   = 0;
        sched(EvCsFall, 8'h00, 1'b0);
        tick(6);
    endtask

    task automatic cs_high();
        tick(Half);
        bus.spi_cs_n = 1'b1;
        sched(EvCsRise, 8'h00, (frame_bits % 8) != 0);
        tick(6);
    endtask

    // Mode 0 master: MOSI changes with SCLK low, MISO sampled just before each rise.
    task automatic send_bits(input logic [7:0] b, input int n, input bit pop_last,
                             output logic [7:0] smp);
        smp = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = b[3'(7 - i)];
            tick(Half);
            smp = {smp[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            cur = {cur[6:0], b[3'(7 - i)]};
            frame_bits++;
            if (frame_bits % 8 == 0) sched(EvByte, cur, 1'b0);
            if (pop_last && i == n - 1) begin
                tick(2);
                bus.rx_ready = 1'b1;
                tick(1);
                bus.rx_ready = 1'b0;
                tick(Half - 3);
            end else begin
                tick(Half);
            end
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string name);
        chk({name, "_valid"}, 32'(bus.rx_valid), 32'd1);
        chk(name, 32'(bus.rx_data), 32'(exp));
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_miso"}, 32'(bus.spi_miso), 32'd0);
        chk({name, "_valid"}, 32'(bus.rx_valid), 32'd0);
        chk({name, "_data"}, 32'(bus.rx_data), 32'd0);
        chk({name, "_pend"}, 32'(bus.tx_pending), 32'd0);
        chk({name, "_ovr"}, 32'(bus.overrun), 32'd0);
        chk({name, "_ferr"}, 32'(bus.frame_err), 32'd0);
        chk({name, "_active"}, 32'(bus.active), 32'd0);
    endtask

    initial begin
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.rx_ready = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_load  = 1'b0;
        tick(2);
        #1 chk_all_zero("reset");
        tick(1);
        rst = 1'b0;
        tick(3);

        // Plain receive with nothing loaded: reply is all ones.
        cs_low();
        send_bits(8'hA5, 8, 1'b0, s);
        chk("a5_data", 32'(bus.rx_data), 32'hA5);
        chk("a5_miso", 32'(s), 32'hFF);
        cs_high();
        pop_expect(8'hA5, "a5_pop");
        chk("a5_empty", 32'(bus.rx_valid), 32'd0);

        // Reply byte loaded before the frame.
        bus.tx_data = 8'h3C;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        bus.tx_data = 8'h00;
        tick(1);
        chk("reply_pend_set", 32'(bus.tx_pending), 32'd1);
        cs_low();
        chk("reply_pend_clr", 32'(bus.tx_pending), 32'd0);
        send_bits(8'h00, 8, 1'b0, s);
        chk("reply_miso", 32'(s), 32'h3C);
        cs_high();
        pop_expect(8'h00, "reply_pop");

        // Six bytes into a four-deep FIFO with no consumer.
        cs_low();
        for (int b = 1; b <= 6; b++) begin
            send_bits(8'(b), 8, 1'b0, s);
            chk("multi_miso", 32'(s), 32'hFF);
        end
        cs_high();
        chk("multi_ovr_count", 32'(ovr_seen), 32'd2);
        for (int b = 1; b <= 4; b++) pop_expect(8'(b), "multi_pop");
        chk("multi_empty", 32'(bus.rx_valid), 32'd0);

        // Full FIFO with a pop on the push cycle.
        cs_low();
        for (int b = 8'h11; b <= 8'h14; b++) send_bits(8'(b), 8, 1'b0, s);
        send_bits(8'h15, 8, 1'b1, s);
        cs_high();
        chk("full_pop_ovr_count", 32'(ovr_seen), 32'd2);
        for (int b = 8'h12; b <= 8'h15; b++) pop_expect(8'(b), "full_pop");
        chk("full_pop_empty", 32'(bus.rx_valid), 32'd0);

        // Aborted frame after five bits, then a clean frame.
        cs_low();
        send_bits(8'hB0, 5, 1'b0, s);
        cs_high();
        chk("abort_ferr_count", 32'(ferr_seen), 32'd1);
        chk("abort_no_push", 32'(bus.rx_valid), 32'd0);
        cs_low();
        send_bits(8'h7E, 8, 1'b0, s);
        cs_high();
        chk("after_abort_ferr", 32'(ferr_seen), 32'd1);
        pop_expect(8'h7E, "after_abort_pop");

        // Reset in the middle of a frame.
        bus.tx_data = 8'h99;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        cs_low();
        send_bits(8'h5A, 3, 1'b0, s);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);
        chk_all_zero("post_rst");
        cs_low();
        send_bits(8'hC3, 8, 1'b0, s);
        chk("post_rst_miso", 32'(s), 32'hFF);
        cs_high();
        pop_expect(8'hC3, "post_rst_pop");
        chk("post_rst_empty", 32'(bus.rx_valid), 32'd0);
        chk("final_ovr_count", 32'(ovr_seen), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_target_rx.md
# spi_target_rx

SPI target (slave) receive/transmit engine: the far end of the SoC's SPI controller. It lets an external SPI master, or a loopback from the SoC's own SPI pins, push bytes into the fabric and read reply bytes back. It runs entirely in the `clk` domain and oversamples SCLK, CS_n and MOSI through synchronizers. Received bytes go into a small RX FIFO with a valid/ready output, and a one-deep TX buffer supplies MISO. It sits beside the SPI controller in `SoC_Peripherals` and is wrapped by an MMIO front-end later.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4, RX FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, default 2, synchronizer flops per SPI input; ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `spi_sclk`  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0)
- `spi_cs_n`  in  1  chip select, active low
- `spi_mosi`  in  1  master-out data, MSB first
- `spi_miso`  out  1  target-out data; 0 while deselected
- `rx_data`  out  8  head of RX FIFO
- `rx_valid`  out  1  FIFO non-empty
- `rx_ready`  in  1  consumer pops head when `rx_valid & rx_ready`
- `tx_data`  in  8  next reply byte
- `tx_load`  in  1  1-cycle strobe: capture `tx_data` into TX buffer
- `tx_pending`  out  1  TX buffer holds a byte not yet consumed
- `overrun`  out  1  1-cycle pulse: completed byte dropped, FIFO full
- `frame_err`  out  1  1-cycle pulse: CS_n rose with a partial byte
- `active`  out  1  frame in progress (state SHIFT)

## Operation
- Synchronizers: reset values sclk=0, cs_n=1, mosi=0. One extra registered copy of sclk/cs_n gives edge detects: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- States:
  - IDLE → SHIFT on `cs_fall`.
  - SHIFT → IDLE on `cs_rise`.
  - SCLK edges are ignored in IDLE.
- Byte framing:
  - `cs_fall`: `bit_cnt`←0, `rx_shift` cleared.
  - Each `sclk_rise` in SHIFT: `rx_shift`←{`rx_shift[6:0]`, mosi}; `bit_cnt`←`bit_cnt`+1 (3 bits, wraps 7→0).
  - On the 8th rise (`bit_cnt`==7), the completed byte {`rx_shift[6:0]`, mosi} is pushed into the FIFO.
- TX path:
  - `spi_miso` = `tx_shift[7]` in SHIFT, else 0.
  - Reload event = `cs_fall`, or a rise that completes a byte. On reload, `tx_shift`←`tx_pending` ? `tx_buf` : 8'hFF, and `tx_pending` clears.
  - On `sclk_fall` with `bit_cnt`≠0: `tx_shift`←`tx_shift`<<1. A fall with `bit_cnt`==0 does not shift, so the MSB holds for the first sample.
  - `tx_load` sets `tx_buf`/`tx_pending`. Load and reload in the same cycle: the reload takes the old `tx_buf`, the new byte is stored, and `tx_pending` stays 1. A `tx_load` while pending overwrites silently.
- FIFO rules:
  - Circular buffer; occupancy counter width $clog2(FIFO_DEPTH+1).
  - A push is accepted if not full, or if a pop happens in the same cycle. Otherwise the byte is dropped and `overrun` pulses.
  - Push and pop together leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `cs_rise` with `bit_cnt`≠0: partial byte discarded, `frame_err` pulses, no push. A `cs_rise` and `sclk_rise` in the same cycle: the CS edge wins and the SCLK edge is ignored.
- Reset (any time, including mid-frame):
  - State IDLE, FIFO empty, `tx_pending`=0, `tx_shift`=8'hFF.
  - All outputs 0: `spi_miso`, `rx_valid`, `tx_pending`, `overrun`, `frame_err`, `active`.
  - `rx_data` = 0. `rx_data` is don't-care while `rx_valid`=0.

## Timing
- Input-to-action latency is SYNC_STAGES+1 clk edges after the external pin edge. With default parameters, `rx_valid` rises at the 3rd `clk` edge after the 8th SCLK rising edge.
- `spi_miso` updates SYNC_STAGES+1 clk edges after the SCLK falling edge, or after the CS_n falling edge for the first bit.
- Constraints:
  - SCLK high and low phases must each be ≥ SYNC_STAGES+2 `clk` periods, which at defaults means f_sclk ≤ f_clk/8.
  - CS_n must fall ≥ SYNC_STAGES+2 clk periods before the first SCLK rise.
  - MOSI must be stable ≥ 1 clk period before each SCLK rise.
- `overrun` and `frame_err` are registered single-cycle pulses.
- `rx_data` and `rx_valid` are registered; a pop takes effect at the next edge.

## Test plan
- Reset then frame: CS low, send 0xA5 mode 0 at clk/8 → `rx_valid`=1, `rx_data`=0xA5 3 clk after the 8th rise; MISO bits all 1 (0xFF, nothing loaded).
- Reply: `tx_load` 0x3C before CS falls, then send 0x00 → master samples 0x3C, `tx_pending` drops at `cs_fall`.
- Multi-byte: send 0x01..0x06 with `rx_ready`=0 → the first 4 bytes are stored, `overrun` pulses on bytes 5 and 6; popping yields 0x01..0x04 in order.
- Full plus simultaneous pop: FIFO full, `rx_ready`=1 on the push cycle → push accepted, no `overrun`, count stays 4.
- Abort: CS_n rises after 5 bits → `frame_err` pulse, no push. The next full frame 0x7E is received correctly.
- Mid-frame `rst` pulse after 3 bits → all outputs 0 immediately. After release, the next CS frame 0xC3 is received correctly.
